// File: rtl/ppa_bk_subtractor_pipe.sv
// Two-stage Brent-Kung subtractor: D = A - B - bin with borrow/overflow/zero flags.
// Stage 1 holds p/g and the prefix up-sweep; stage 2 finishes the down-sweep.
module ppa_bk_subtractor_pipe #(
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int LV = $clog2(WIDTH);

  logic             s1_v_q, s1_v_d;
  logic             s2_v_q, s2_v_d;
  logic             s1_load, s2_adv;

  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic [WIDTH-1:0] gu_q, gu_d;
  logic [WIDTH-1:0] pu_q, pu_d;
  logic             cin_q, cin_d;
  logic             am_q, am_d;
  logic             bm_q, bm_d;

  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  always_comb begin : flow
    s2_adv   = s1_v_q & (~s2_v_q | out_ready);
    in_ready = ~s1_v_q | s2_adv;
    s1_load  = in_valid & in_ready;
    s1_v_d   = s1_load | (s1_v_q & ~s2_adv);
    s2_v_d   = s2_adv | (s2_v_q & ~out_ready);
  end

  always_comb begin : stage1
    logic [WIDTH-1:0] pt, gt;
    pt = A ^ ~B;
    gt = A & ~B;
    p_d   = s1_load ? pt : p_q;
    g_d   = s1_load ? gt : g_q;
    cin_d = s1_load ? ~bin : cin_q;
    am_d  = s1_load ? A[WIDTH-1] : am_q;
    bm_d  = s1_load ? B[WIDTH-1] : bm_q;
    // Up-sweep: node i at level l spans (i-2^l, i]; partners are never
    // rewritten in the same level, so in-place update is safe.
    for (int l = 1; l <= LV; l++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (((i + 1) % (1 << l)) == 0) begin
          gt[i] = gt[i] | (pt[i] & gt[i - (1 << (l - 1))]);
          pt[i] = pt[i] & pt[i - (1 << (l - 1))];
        end
      end
    end
    gu_d = s1_load ? gt : gu_q;
    pu_d = s1_load ? pt : pu_q;
  end

  always_comb begin : stage2
    logic [WIDTH-1:0] gd, pd, c, dn;
    logic             cout;
    gd = gu_q;
    pd = pu_q;
    for (int k = LV - 1; k >= 1; k--) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << k) &&
            ((i + 1) % (1 << k)) == (1 << (k - 1))) begin
          gd[i] = gd[i] | (pd[i] & gd[i - (1 << (k - 1))]);
          pd[i] = pd[i] & pd[i - (1 << (k - 1))];
        end
      end
    end
    c[0] = cin_q;
    for (int i = 1; i < WIDTH; i++) begin
      c[i] = gd[i-1] | (pd[i-1] & cin_q);
    end
    cout   = gd[WIDTH-1] | (pd[WIDTH-1] & cin_q);
    dn     = p_q ^ c;
    d_d    = s2_adv ? dn : d_q;
    bout_d = s2_adv ? ~cout : bout_q;
    ovf_d  = s2_adv ? ((am_q ^ bm_q) & (dn[WIDTH-1] ^ am_q)) : ovf_q;
    zero_d = s2_adv ? ~|dn : zero_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      p_q    <= '0;
      g_q    <= '0;
      gu_q   <= '0;
      pu_q   <= '0;
      cin_q  <= 1'b0;
      am_q   <= 1'b0;
      bm_q   <= 1'b0;
      d_q    <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      p_q    <= p_d;
      g_q    <= g_d;
      gu_q   <= gu_d;
      pu_q   <= pu_d;
      cin_q  <= cin_d;
      am_q   <= am_d;
      bm_q   <= bm_d;
      d_q    <= d_d;
      bout_q <= bout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = s2_v_q;
  assign D         = d_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_ppa_bk_subtractor_pipe.sv
// Bench for ppa_bk_subtractor_pipe: arithmetic reference model with an
// in-order expectation queue, plus directed literal vectors.
module tb_ppa_bk_subtractor_pipe;

  localparam int W = 22;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    logic         zero;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] D;
  logic         bout;
  logic         ovf;
  logic         zero;

  int   checks = 0;
  int   errors = 0;
  res_t q[$];
  bit   done;

  ppa_bk_subtractor_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .bout(bout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b,
                                 logic bi);
    res_t r;
    longint ua, ub, sa, sb, df, st, lim;
    ua  = longint'(a);
    ub  = longint'(b);
    lim = longint'(1) << (W - 1);
    sa  = a[W-1] ? ua - 2 * lim : ua;
    sb  = b[W-1] ? ub - 2 * lim : ub;
    df  = ua - ub - longint'(bi);
    st  = sa - sb - longint'(bi);
    r.d    = W'(df);
    r.bout = ua < ub + longint'(bi);
    r.ovf  = (st < -lim) || (st >= lim);
    r.zero = (r.d == '0);
    return r;
  endfunction

  // Compare process: front of queue must be on the outputs whenever valid.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_valid", 64'(out_valid), 64'(0));
        end else begin
          check("D", 64'(D), 64'(q[0].d));
          check("bout", 64'(bout), 64'(q[0].bout));
          check("ovf", 64'(ovf), 64'(q[0].ovf));
          check("zero", 64'(zero), 64'(q[0].zero));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(model(A, B, bin));
    end
  end

  task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic bi);
    bit acc;
    int n;
    A = a; B = b; bin = bi; in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic expect_lit(string nm, logic [W-1:0] d, logic bo,
                            logic ov, logic z);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_valid"}, 64'(out_valid), 64'(1));
    check({nm, "_D"}, 64'(D), 64'(d));
    check({nm, "_bout"}, 64'(bout), 64'(bo));
    check({nm, "_ovf"}, 64'(ovf), 64'(ov));
    check({nm, "_zero"}, 64'(zero), 64'(z));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(string nm);
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(nm, 64'(q.size()), 64'(0));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; bin = 1'b0; done = 1'b0;

    check("pin_basic", 64'(model(22'h000005, 22'h000003, 1'b0)),
          64'({22'h000002, 1'b0, 1'b0, 1'b0}));
    check("pin_wrap", 64'(model(22'h000000, 22'h000001, 1'b0)),
          64'({22'h3FFFFF, 1'b1, 1'b0, 1'b0}));
    check("pin_zero", 64'(model(22'h000001, 22'h000000, 1'b1)),
          64'({22'h000000, 1'b0, 1'b0, 1'b1}));
    check("pin_ovf1", 64'(model(22'h1FFFFF, 22'h3FFFFF, 1'b0)),
          64'({22'h200000, 1'b1, 1'b1, 1'b0}));
    check("pin_ovf2", 64'(model(22'h200000, 22'h000001, 1'b0)),
          64'({22'h1FFFFF, 1'b0, 1'b1, 1'b0}));

    repeat (3) @(posedge clk);
    #3;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_D", 64'(D), 64'(0));
    check("rst_flags", 64'({bout, ovf, zero}), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rel_in_ready", 64'(in_ready), 64'(1));

    send(22'h000005, 22'h000003, 1'b0);
    check("lat_accept_edge", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    check("lat_next_edge", 64'(out_valid), 64'(1));
    expect_lit("basic", 22'h000002, 1'b0, 1'b0, 1'b0);

    send(22'h000000, 22'h000001, 1'b0);
    expect_lit("wrap", 22'h3FFFFF, 1'b1, 1'b0, 1'b0);
    send(22'h000001, 22'h000000, 1'b1);
    expect_lit("zero", 22'h000000, 1'b0, 1'b0, 1'b1);
    send(22'h1FFFFF, 22'h3FFFFF, 1'b0);
    expect_lit("ovf1", 22'h200000, 1'b1, 1'b1, 1'b0);
    send(22'h200000, 22'h000001, 1'b0);
    expect_lit("ovf2", 22'h1FFFFF, 1'b0, 1'b1, 1'b0);
    drain("drain_directed");

    out_ready = 1'b0;
    fork
      begin
        send(22'h000010, 22'h000001, 1'b0);
        send(22'h000020, 22'h000002, 1'b1);
        send(22'h000030, 22'h000040, 1'b0);
        send(22'h3FFFFF, 22'h3FFFFF, 1'b1);
        send(22'h123456, 22'h023456, 1'b0);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("full_in_ready", 64'(in_ready), 64'(0));
        check("full_out_valid", 64'(out_valid), 64'(1));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("popush_in_ready", 64'(in_ready), 64'(1));
      end
    join
    drain("drain_backpressure");

    out_ready = 1'b0;
    send(22'h000100, 22'h000001, 1'b0);
    send(22'h000200, 22'h000002, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_D", 64'(D), 64'(0));
    check("mid_rst_flags", 64'({bout, ovf, zero}), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    send(22'h000007, 22'h000002, 1'b1);
    check("post_rst_lat0", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    check("post_rst_lat1", 64'(out_valid), 64'(1));
    expect_lit("post_rst", 22'h000004, 1'b0, 1'b0, 1'b0);
    drain("drain_reset");

    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          case ($urandom_range(0, 7))
            0: send(W'($urandom), W'($urandom_range(0, 1)),
                    1'($urandom));
            1: send(22'h200000 ^ W'($urandom_range(0, 1)), W'($urandom),
                    1'($urandom));
            default: send(W'($urandom), W'($urandom), 1'($urandom));
          endcase
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain("drain_random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
